shape_rom_burst_arbiter: RTL and testbench
==========================================

# shape_rom_burst_arbiter

Shares one registered shape ROM (60 rows × 51 bits, 6-bit row address, 2-bit orientation, one-cycle address-to-data latency) between several sprite requesters. It arbitrates burst requests, sequences consecutive row addresses into the ROM at one row per cycle, and returns each row tagged with requester ID and row index. It sits between the obstacle/pipe render engines and the shape ROM instance.

## Interface
- NREQ, 4: number of requesters (2..8); IDW = clog2(NREQ)
- ROWS, 60: valid ROM rows; row indices ≥ ROWS return zero data
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester burst request, held until granted
- req_start  in  NREQ*6  start row, requester i at bits [6i+5:6i]
- req_count  in  NREQ*6  rows in burst, 1..63; 0 treated as 1
- req_orient  in  NREQ*2  orientation for burst
- gnt  out  NREQ  one-hot; burst accepted at rising edge where req[i]&gnt[i]
- rom_address  out  6  registered ROM row address
- rom_orientation  out  2  registered ROM orientation
- rom_data  in  51  ROM output, valid one cycle after rom_address
- rsp_valid  out  1  response beat valid
- rsp_data  out  51  row bits
- rsp_id  out  IDW  requester owning the beat
- rsp_row  out  6  row index of the beat
- rsp_last  out  1  final beat of burst

## Operation
- States: IDLE, BURST. Registers: addr, orient, owner, remaining (6 bit), rr_ptr.
- gnt combinational: nonzero only in IDLE, or in BURST with remaining==0; selects one pending req by arbitration policy; at most one bit set.
- Grant edge: addr<=req_start, orient<=req_orient, owner<=i, remaining<=max(count,1)-1, state<=BURST, rr_ptr<=(i+1) mod NREQ.
- BURST, remaining>0: each edge addr<=addr+1, remaining<=remaining-1.
- BURST, remaining==0: edge loads new burst if any grant, else state<=IDLE.
- Round-robin: search starts at rr_ptr, ascending with wrap.
- 2-stage tag pipeline follows issued address: {valid, owner, row, last, zero}; zero set when row ≥ ROWS or 7-bit start+k ≥ 64 (address wrap); zero beats force rsp_data=0, rsp_row= low 6 bits.
- Orientation 3 passed through; ROM returns zero.
- No response backpressure; requesters accept every beat.

## Timing
- Reset values: gnt=0 (IDLE, no req effect during rst), rom_address=0, rom_orientation=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_row=0, rsp_last=0, rr_ptr=0, state IDLE.
- Grant edge E: beat k address on rom_address after edge E+k; ROM captures at E+k+1; rsp_* for beat k valid after edge E+k+2 (2-cycle grant-to-first-beat).
- Throughput: one row per cycle; back-to-back bursts with zero bubbles (next gnt in cycle of previous last address).
- Simultaneous requests: exactly one granted per grant slot; losers keep req high.
- req dropped before grant: no effect. req changes after grant: ignored for current burst.
- rst mid-burst: all in-flight beats dropped; rsp_valid=0 from the edge where rst sampled; state IDLE.
- rsp_last asserted on beat remaining==0 only; single-row burst has rsp_last on its only beat.

## Configuration
- SHAPE_ARB_FIXED_PRIO_EN: defined → fixed priority, lowest index wins, rr_ptr unused. Undefined (default) → round-robin as above.

## Test plan
- Single burst: req0, start=0, count=3, orient=0 → gnt[0] one cycle; beats rows 0,1,2 starting 2 cycles later; row0 data has only bit 25 set; rsp_last on row 2.
- Contention: req0..3 all high, count=1 each, round-robin → grants 0,1,2,3 on consecutive cycles; rsp_id sequence 0,1,2,3 with no gaps.
- Boundary: start=58, count=4 → rows 58,59 ROM data, rows 60,61 zero, rsp_last on 61; start=62, count=4 → rows 62,63 then wrapped 0,1 all zero.
- count=0 → exactly one beat, rsp_last=1; orientation=3 → rsp_data=0.
- Reset mid-burst: start=10, count=20, assert rst on 5th beat → rsp_valid low next cycle, no further beats, gnt available after rst deasserts.
- With SHAPE_ARB_FIXED_PRIO_EN: req0 and req2 held high continuously → req0 granted every slot, req2 never granted.

Source files
------------

// File: rtl/shape_rom_burst_arbiter.sv
// shape_rom_burst_arbiter
// Shares one registered shape ROM (one-cycle address-to-data latency) between
// NREQ sprite requesters. A granted burst streams consecutive row addresses
// into the ROM at one row per cycle. Each returned row is tagged with the owner
// ID, the row index and a last-beat flag.
// Build option: define SHAPE_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. When it is undefined (the default), arbitration is
// round-robin.
//
// Handshake: req[i] is a valid that the requester holds until it is accepted.
// gnt[i] is the combinational ready. The burst transfers on the rising edge
// where req[i] & gnt[i]. Responses have no backpressure: every beat with
// rsp_valid high is consumed.
module shape_rom_burst_arbiter #(
    parameter int NREQ = 4,
    parameter int ROWS = 60,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*6-1:0]   req_start,
    input  logic [NREQ*6-1:0]   req_count,
    input  logic [NREQ*2-1:0]   req_orient,
    output logic [NREQ-1:0]     gnt,
    output logic [5:0]          rom_address,
    output logic [1:0]          rom_orientation,
    input  logic [50:0]         rom_data,
    output logic                rsp_valid,
    output logic [50:0]         rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic [5:0]          rsp_row,
    output logic                rsp_last
);

    localparam logic [6:0] ROWS7 = 7'(ROWS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t         state;
    logic [6:0]     seq7;        // start + k, seven bits so address wrap is visible
    logic [1:0]     orient;
    logic [IDW-1:0] owner;
    logic [5:0]     remaining;
    logic [IDW-1:0] rr_ptr;

    logic           slot_open;
    logic [IDW-1:0] gnt_idx;
    logic           found;
    int             idx;
    logic [5:0]     sel_start;
    logic [5:0]     sel_count;
    logic [1:0]     sel_orient;

    logic           s1_valid;
    logic           s1_last;
    logic           s1_zero;

    logic           s2_valid;
    logic [IDW-1:0] s2_owner;
    logic [5:0]     s2_row;
    logic           s2_last;
    logic           s2_zero;

    // A new burst may start when the sequencer is idle or is issuing its last row.
    assign slot_open = (state == IDLE) || (remaining == 6'd0);

    // Pick one pending requester. The search starts at rr_ptr, or at 0 in fixed mode.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (slot_open && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef SHAPE_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (int'(rr_ptr) + k) % NREQ;
`endif
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = IDW'(idx);
                end
            end
        end
    end

    assign sel_start  = req_start[gnt_idx*6 +: 6];
    assign sel_count  = req_count[gnt_idx*6 +: 6];
    assign sel_orient = req_orient[gnt_idx*2 +: 2];

    // Burst sequencer: load on a grant, otherwise step through the rows, otherwise go idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            seq7      <= '0;
            orient    <= '0;
            owner     <= '0;
            remaining <= '0;
            rr_ptr    <= '0;
        end else if (|gnt) begin
            state     <= BURST;
            seq7      <= {1'b0, sel_start};
            orient    <= sel_orient;
            owner     <= gnt_idx;
            remaining <= (sel_count == 6'd0) ? 6'd0 : sel_count - 6'd1;
            if (gnt_idx == IDW'(NREQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_idx + 1'b1;
        end else if (state == BURST) begin
            if (remaining != 6'd0) begin
                seq7      <= seq7 + 7'd1;
                remaining <= remaining - 6'd1;
            end else begin
                state     <= IDLE;
            end
        end
    end

    assign rom_address     = seq7[5:0];
    assign rom_orientation = orient;

    // Tag of the row currently on rom_address.
    assign s1_valid = (state == BURST);
    assign s1_last  = (remaining == 6'd0);
    assign s1_zero  = seq7[6] || ({1'b0, seq7[5:0]} >= ROWS7);

    // Delay the tag so that it meets the ROM data, then register the response beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_owner  <= '0;
            s2_row    <= '0;
            s2_last   <= 1'b0;
            s2_zero   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_row   <= '0;
            rsp_last  <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_owner  <= owner;
            s2_row    <= seq7[5:0];
            s2_last   <= s1_valid && s1_last;
            s2_zero   <= s1_zero;
            rsp_valid <= s2_valid;
            rsp_data  <= (s2_valid && !s2_zero) ? rom_data : '0;
            rsp_id    <= s2_owner;
            rsp_row   <= s2_row;
            rsp_last  <= s2_valid && s2_last;
        end
    end

endmodule

// File: tb/tb_shape_rom_burst_arbiter.sv
// tb_shape_rom_burst_arbiter
// Directed bench for shape_rom_burst_arbiter. It has a behavioural registered
// ROM, an expected-beat queue checked by a response monitor, and per-test
// grant and timing checks.
module tb_shape_rom_burst_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 60;   // {id[2], row[6], last[1], data[51]}

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*6-1:0] req_start = '0;
    logic [NREQ*6-1:0] req_count = '0;
    logic [NREQ*2-1:0] req_orient = '0;
    logic [NREQ-1:0]   gnt;
    logic [5:0]        rom_address;
    logic [1:0]        rom_orientation;
    logic [50:0]       rom_data = '0;
    logic              rsp_valid;
    logic [50:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic [5:0]        rsp_row;
    logic              rsp_last;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];
    int           beat_cyc[$];
    logic [W-1:0] mon_e;

    shape_rom_burst_arbiter #(.NREQ(NREQ), .ROWS(60)) dut (
        .clk(clk), .rst(rst), .req(req), .req_start(req_start),
        .req_count(req_count), .req_orient(req_orient), .gnt(gnt),
        .rom_address(rom_address), .rom_orientation(rom_orientation),
        .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_row(rsp_row), .rsp_last(rsp_last)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: row 0 / orient 0 has only bit 25 set; orient 3 reads as zero.
    // Rows >= 60 deliberately read as nonzero so that the zero forcing is visible.
    function automatic logic [50:0] rom_f(input logic [5:0] a, input logic [1:0] o);
        if (o == 2'd3) return '0;
        return (51'd1 << 25) | ({45'd0, a} << 26) | {49'd0, o};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_address, rom_orientation);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: every valid beat must match the head of exp_q
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id",   64'(rsp_id),   64'(mon_e[59:58]));
                check("rsp_row",  64'(rsp_row),  64'(mon_e[57:52]));
                check("rsp_last", 64'(rsp_last), 64'(mon_e[51]));
                check("rsp_data", 64'(rsp_data), 64'(mon_e[50:0]));
                beat_cyc.push_back(cyc);
            end
        end
    end

    task automatic push_beats(input int id, input logic [5:0] start,
                              input logic [5:0] count, input logic [1:0] orient);
        int n;
        logic [6:0] s7;
        logic [5:0] row;
        logic zero;
        logic [50:0] d;
        n = (count == 6'd0) ? 1 : int'(count);
        for (int k = 0; k < n; k++) begin
            s7   = {1'b0, start} + 7'(k);
            row  = s7[5:0];
            zero = s7[6] || (row >= 6'd60);
            d    = zero ? 51'd0 : rom_f(row, orient);
            exp_q.push_back({2'(id), row, (k == n - 1), d});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        beat_cyc.delete();
    endtask

    task automatic set_req(input int id, input logic [5:0] s, input logic [5:0] c,
                           input logic [1:0] o);
        req_start[id*6 +: 6]  = s;
        req_count[id*6 +: 6]  = c;
        req_orient[id*2 +: 2] = o;
        req[id] = 1'b1;
    endtask

    // driver: raise req[id], wait (bounded) for its grant, and drop req after the accept edge
    task automatic run_burst(input int id, input logic [5:0] s, input logic [5:0] c,
                             input logic [1:0] o, output int gcyc);
        logic got;
        logic [3:0] m;
        got  = 1'b0;
        gcyc = -1;
        m    = 4'b0001 << id;
        set_req(id, s, c, o);
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (gnt[id]) got = 1'b1;
        end
        check("gnt_onehot", 64'(gnt), 64'(m));
        if (!got) begin
            req[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 gcyc = cyc;
        req[id] = 1'b0;
        push_beats(id, s, c, o);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // beats must land exactly 2 cycles after the first grant, back to back
    task automatic check_beat_times(input int g0, input int n);
        check("beat_count", 64'(beat_cyc.size()), 64'(n));
        for (int k = 0; k < n && k < beat_cyc.size(); k++)
            check("beat_cycle", 64'(beat_cyc[k]), 64'(g0 + 2 + k));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g;
        int g0;
        logic [3:0] m;
        int seq_id[4];

        // reset state, with every req high during reset
        req = '1;
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt",      64'(gnt), 64'd0);
        check("rst_rom_addr", 64'(rom_address), 64'd0);
        check("rst_rom_or",   64'(rom_orientation), 64'd0);
        check("rst_valid",    64'(rsp_valid), 64'd0);
        check("rst_data",     64'(rsp_data), 64'd0);
        check("rst_id",       64'(rsp_id), 64'd0);
        check("rst_row",      64'(rsp_row), 64'd0);
        check("rst_last",     64'(rsp_last), 64'd0);
        do_reset();

        // single burst: rows 0,1,2 and addresses on consecutive cycles
        run_burst(0, 6'd0, 6'd3, 2'd0, g);
        @(negedge clk);
        check("addr_k0", 64'(rom_address), 64'd0);
        check("orient",  64'(rom_orientation), 64'd0);
        @(negedge clk);
        check("addr_k1", 64'(rom_address), 64'd1);
        @(negedge clk);
        check("addr_k2", 64'(rom_address), 64'd2);
        wait_drain();
        check_beat_times(g, 3);

        // contention: four single-row requests, granted 0,1,2,3 with no gaps
        do_reset();
        for (int j = 0; j < 4; j++) set_req(j, 6'(20 + j), 6'd1, 2'(j));
        g0 = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            m = 4'b0001 << j;
            check("rr_gnt", 64'(gnt), 64'(m));
            @(posedge clk);
            #1 if (j == 0) g0 = cyc;
            req[j] = 1'b0;
            push_beats(j, 6'(20 + j), 6'd1, 2'(j));
        end
        wait_drain();
        check_beat_times(g0, 4);

        // boundary: rows past the end of the table, then address wrap
        do_reset();
        run_burst(1, 6'd58, 6'd4, 2'd1, g);
        wait_drain();
        check_beat_times(g, 4);
        do_reset();
        run_burst(3, 6'd62, 6'd4, 2'd2, g);
        wait_drain();
        check_beat_times(g, 4);

        // count 0 gives one beat; orientation 3 gives zero data
        do_reset();
        run_burst(2, 6'd5, 6'd0, 2'd1, g);
        wait_drain();
        check_beat_times(g, 1);
        do_reset();
        run_burst(1, 6'd3, 6'd2, 2'd3, g);
        wait_drain();
        check_beat_times(g, 2);

        // back-to-back: the second grant shows up while the last address of the first is issued
        do_reset();
        set_req(1, 6'd30, 6'd2, 2'd0);
        set_req(2, 6'd50, 6'd2, 2'd1);
        @(negedge clk);
        check("b2b_gnt1", 64'(gnt), 64'h2);
        @(posedge clk);
        #1 g0 = cyc;
        req[1] = 1'b0;
        push_beats(1, 6'd30, 6'd2, 2'd0);
        @(negedge clk);
        check("b2b_closed", 64'(gnt), 64'd0);
        @(negedge clk);
        check("b2b_addr", 64'(rom_address), 64'd31);
        check("b2b_gnt2", 64'(gnt), 64'h4);
        @(posedge clk);
        #1 req[2] = 1'b0;
        push_beats(2, 6'd50, 6'd2, 2'd1);
        wait_drain();
        check_beat_times(g0, 4);

        // req0 and req2 held high across four grant slots
`ifdef SHAPE_ARB_FIXED_PRIO_EN
        seq_id = '{0, 0, 0, 0};
`else
        seq_id = '{0, 2, 0, 2};
`endif
        do_reset();
        set_req(0, 6'd7, 6'd1, 2'd0);
        set_req(2, 6'd40, 6'd1, 2'd2);
        g0 = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            m = 4'b0001 << seq_id[j];
            check("hold_gnt", 64'(gnt), 64'(m));
            @(posedge clk);
            #1 if (j == 0) g0 = cyc;
            if (seq_id[j] == 0) push_beats(0, 6'd7, 6'd1, 2'd0);
            else                push_beats(2, 6'd40, 6'd1, 2'd2);
        end
        req = '0;
        wait_drain();
        check_beat_times(g0, 4);

        // reset in the middle of a burst: 5 beats arrive, then nothing
        do_reset();
        run_burst(0, 6'd10, 6'd20, 2'd1, g);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        set_req(0, 6'd0, 6'd1, 2'd0);
        @(negedge clk);
        check("rst_mid_gnt", 64'(gnt), 64'd0);
        @(posedge clk);
        #1 check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_left", 64'(exp_q.size()), 64'd15);
        check("rst_mid_beats", 64'(beat_cyc.size()), 64'd5);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        beat_cyc.delete();
        @(negedge clk);
        check("post_rst_gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        #1 g = cyc;
        req[0] = 1'b0;
        push_beats(0, 6'd0, 6'd1, 2'd0);
        wait_drain();
        check_beat_times(g, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
